// File: rtl/ddr3_clk_pkg.sv
// ----------------------------------------------------------------------------
// ddr3_clk_pkg
// Shared types and constants for the DDR3 PLL startup/recovery sequencer:
//   - state_e      : sequencer states
//   - pll_cfg_t    : dynamic PLL tuning payload {icp, lpfres}
//   - PLL_*_DEFAULT: default charge-pump / loop-filter settings
//   - sweep_entry(): 4-entry retry sweep table (used when PLL_CTRL_SWEEP_EN)
// ----------------------------------------------------------------------------
package ddr3_clk_pkg;

    localparam int unsigned ICP_W    = 6;
    localparam int unsigned LPFRES_W = 3;
    localparam int unsigned LPFCAP_W = 2;
    localparam int unsigned RETRY_W  = 3;
    localparam int unsigned CNT_W    = 16;

    localparam logic [ICP_W-1:0]    PLL_ICP_DEFAULT     = 6'd20;
    localparam logic [LPFRES_W-1:0] PLL_LPF_RES_DEFAULT = 3'd2;
    localparam logic [LPFCAP_W-1:0] PLL_LPF_CAP_DEFAULT = 2'd0;

    typedef enum logic [2:0] {
        RESET_HOLD = 3'd0,
        WAIT_LOCK  = 3'd1,
        ENABLE     = 3'd2,
        RUN        = 3'd3,
        FAIL       = 3'd4
    } state_e;

    typedef struct packed {
        logic [ICP_W-1:0]    icp;
        logic [LPFRES_W-1:0] lpfres;
    } pll_cfg_t;

    // Retry sweep table, relative to the configured defaults.
    function automatic pll_cfg_t sweep_entry(input logic [1:0]          idx,
                                             input logic [ICP_W-1:0]    icp_def,
                                             input logic [LPFRES_W-1:0] res_def);
        pll_cfg_t cfg;
        cfg.icp    = icp_def;
        cfg.lpfres = res_def;
        case (idx)
            2'd1: cfg.icp = icp_def + 6'd8;
            2'd2: begin
                cfg.icp    = icp_def - 6'd8;
                cfg.lpfres = res_def + 3'd1;
            end
            2'd3: cfg.lpfres = res_def + 3'd2;
            default: ;
        endcase
        return cfg;
    endfunction

endpackage

// File: rtl/ddr3_pll_lock_sync.sv
// ----------------------------------------------------------------------------
// ddr3_pll_lock_sync
// Brings an asynchronous PLL LOCK into the clk domain with a 2-flop
// synchronizer and flags a lock loss once the synchronized lock has been low
// for two consecutive cycles (single-cycle dropouts are ignored).
//   clk          in   sampling clock (free-running, not from the PLL)
//   resetn       in   async active-low reset
//   lock_async   in   raw PLL LOCK
//   lock_s       out  synchronized lock (registered)
//   lock_lost_c  out  lock_s low this cycle and the previous one (combinational)
// ----------------------------------------------------------------------------
module ddr3_pll_lock_sync (
    input  logic clk,
    input  logic resetn,
    input  logic lock_async,
    output logic lock_s,
    output logic lock_lost_c
);

    logic lock_meta;
    logic lock_prev;

    // Synchronizer chain plus one history flop for the loss detector.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
            lock_prev <= 1'b0;
        end else begin
            lock_meta <= lock_async;
            lock_s    <= lock_meta;
            lock_prev <= lock_s;
        end
    end

    assign lock_lost_c = ~lock_s & ~lock_prev;

endmodule

// File: rtl/ddr3_pll_ctrl.sv
// ----------------------------------------------------------------------------
// ddr3_pll_ctrl
// Startup/recovery sequencer for the DDR3 PLL. Runs on the 27 MHz board
// oscillator (same source as the PLL CLKIN) so it never depends on PLL
// outputs. Holds the PLL in reset, waits for a stable lock, gates the PLL
// clock outputs on, then releases the DDR3 controller reset. Re-sequences on
// lock loss or soft reset; gives up after MAX_RETRY lock timeouts.
//
// Optional feature: define PLL_CTRL_SWEEP_EN to step the {icp,lpfres}
// settings through a 4-entry table on each lock timeout.
//
// Ports:
//   clk          in   27 MHz oscillator
//   resetn       in   async active-low reset
//   soft_rst     in   sync pulse, restarts from RESET_HOLD and clears retries
//   pll_lock     in   raw PLL LOCK (asynchronous)
//   pll_reset    out  PLL RESET, active high
//   pll_icpsel   out  PLL ICPSEL
//   pll_lpfres   out  PLL LPFRES
//   pll_lpfcap   out  PLL LPFCAP
//   pll_enclk0   out  PLL ENCLK0 (DDR3 fast clock)
//   pll_enclk2   out  PLL ENCLK2
//   ddr_rst_n    out  DDR3 controller reset, active low
//   ready        out  high in RUN
//   fail         out  high in FAIL
//   retry_cnt    out  lock timeouts since last reset, saturating at 7
// ----------------------------------------------------------------------------
module ddr3_pll_ctrl
    import ddr3_clk_pkg::*;
#(
    parameter int unsigned          RST_CYCLES   = 32,
    parameter int unsigned          LOCK_TIMEOUT = 27000,
    parameter int unsigned          LOCK_STABLE  = 256,
    parameter int unsigned          ENABLE_DLY   = 64,
    parameter int unsigned          MAX_RETRY    = 4,
    parameter logic [ICP_W-1:0]     ICP_DEFAULT  = PLL_ICP_DEFAULT,
    parameter logic [LPFRES_W-1:0]  LPF_RES_DEF  = PLL_LPF_RES_DEFAULT,
    parameter logic [LPFCAP_W-1:0]  LPF_CAP_DEF  = PLL_LPF_CAP_DEFAULT
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                soft_rst,
    input  logic                pll_lock,
    output logic                pll_reset,
    output logic [ICP_W-1:0]    pll_icpsel,
    output logic [LPFRES_W-1:0] pll_lpfres,
    output logic [LPFCAP_W-1:0] pll_lpfcap,
    output logic                pll_enclk0,
    output logic                pll_enclk2,
    output logic                ddr_rst_n,
    output logic                ready,
    output logic                fail,
    output logic [RETRY_W-1:0]  retry_cnt
);

    localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0]   ENABLE_LAST  = CNT_W'(ENABLE_DLY - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRY);
    localparam logic [RETRY_W-1:0] RETRY_SAT    = '1;

    logic lock_s;
    logic lock_lost_c;

    ddr3_pll_lock_sync u_lock_sync (
        .clk         (clk),
        .resetn      (resetn),
        .lock_async  (pll_lock),
        .lock_s      (lock_s),
        .lock_lost_c (lock_lost_c)
    );

    state_e               state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [CNT_W-1:0]     stable_cnt, stable_cnt_nxt;
    logic                 pll_reset_nxt;
    logic [ICP_W-1:0]     icpsel_nxt;
    logic [LPFRES_W-1:0]  lpfres_nxt;
    logic                 enclk_nxt;
    logic                 ddr_rst_n_nxt;
    logic                 ready_nxt;
    logic                 fail_nxt;
    logic [RETRY_W-1:0]   retry_nxt;
    logic [RETRY_W-1:0]   retry_inc;

    assign retry_inc = (retry_cnt == RETRY_SAT) ? RETRY_SAT : retry_cnt + RETRY_W'(1);

    // Next-state and next-output logic; every transition clears the counters.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt + CNT_W'(1);
        stable_cnt_nxt = stable_cnt;
        pll_reset_nxt  = pll_reset;
        icpsel_nxt     = pll_icpsel;
        lpfres_nxt     = pll_lpfres;
        enclk_nxt      = pll_enclk0;
        ddr_rst_n_nxt  = ddr_rst_n;
        ready_nxt      = ready;
        fail_nxt       = fail;
        retry_nxt      = retry_cnt;

        case (state)
            RESET_HOLD: begin
                if (cnt == RST_LAST) begin
                    state_nxt      = WAIT_LOCK;
                    cnt_nxt        = '0;
                    stable_cnt_nxt = '0;
                    pll_reset_nxt  = 1'b0;
                end
            end

            WAIT_LOCK: begin
                // Stability count restarts on any cycle without lock.
                stable_cnt_nxt = lock_s ? stable_cnt + CNT_W'(1) : '0;
                if (lock_s && stable_cnt == STABLE_LAST) begin
                    state_nxt      = ENABLE;
                    cnt_nxt        = '0;
                    stable_cnt_nxt = '0;
                    enclk_nxt      = 1'b1;
                end else if (cnt == TIMEOUT_LAST) begin
                    cnt_nxt        = '0;
                    stable_cnt_nxt = '0;
                    pll_reset_nxt  = 1'b1;
                    retry_nxt      = retry_inc;
`ifdef PLL_CTRL_SWEEP_EN
                    {icpsel_nxt, lpfres_nxt} = sweep_entry(retry_inc[1:0], ICP_DEFAULT, LPF_RES_DEF);
`endif
                    if (retry_inc == RETRY_MAX) begin
                        state_nxt = FAIL;
                        fail_nxt  = 1'b1;
                    end else begin
                        state_nxt = RESET_HOLD;
                    end
                end
            end

            ENABLE: begin
                if (lock_lost_c) begin
                    state_nxt     = RESET_HOLD;
                    cnt_nxt       = '0;
                    pll_reset_nxt = 1'b1;
                    enclk_nxt     = 1'b0;
                end else if (cnt == ENABLE_LAST) begin
                    state_nxt     = RUN;
                    cnt_nxt       = '0;
                    ddr_rst_n_nxt = 1'b1;
                    ready_nxt     = 1'b1;
                end
            end

            RUN: begin
                cnt_nxt = '0;
                if (lock_lost_c) begin
                    state_nxt     = RESET_HOLD;
                    pll_reset_nxt = 1'b1;
                    enclk_nxt     = 1'b0;
                    ddr_rst_n_nxt = 1'b0;
                    ready_nxt     = 1'b0;
                end
            end

            FAIL: begin
                cnt_nxt = '0;
            end

            default: begin
                state_nxt     = RESET_HOLD;
                cnt_nxt       = '0;
                pll_reset_nxt = 1'b1;
                enclk_nxt     = 1'b0;
                ddr_rst_n_nxt = 1'b0;
                ready_nxt     = 1'b0;
            end
        endcase

        // Soft reset overrides every transition above.
        if (soft_rst) begin
            state_nxt      = RESET_HOLD;
            cnt_nxt        = '0;
            stable_cnt_nxt = '0;
            pll_reset_nxt  = 1'b1;
            icpsel_nxt     = ICP_DEFAULT;
            lpfres_nxt     = LPF_RES_DEF;
            enclk_nxt      = 1'b0;
            ddr_rst_n_nxt  = 1'b0;
            ready_nxt      = 1'b0;
            fail_nxt       = 1'b0;
            retry_nxt      = '0;
        end
    end

    // State, counters and all outputs registered.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= RESET_HOLD;
            cnt        <= '0;
            stable_cnt <= '0;
            pll_reset  <= 1'b1;
            pll_icpsel <= ICP_DEFAULT;
            pll_lpfres <= LPF_RES_DEF;
            pll_lpfcap <= LPF_CAP_DEF;
            pll_enclk0 <= 1'b0;
            pll_enclk2 <= 1'b0;
            ddr_rst_n  <= 1'b0;
            ready      <= 1'b0;
            fail       <= 1'b0;
            retry_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            stable_cnt <= stable_cnt_nxt;
            pll_reset  <= pll_reset_nxt;
            pll_icpsel <= icpsel_nxt;
            pll_lpfres <= lpfres_nxt;
            pll_lpfcap <= LPF_CAP_DEF;
            pll_enclk0 <= enclk_nxt;
            pll_enclk2 <= enclk_nxt;
            ddr_rst_n  <= ddr_rst_n_nxt;
            ready      <= ready_nxt;
            fail       <= fail_nxt;
            retry_cnt  <= retry_nxt;
        end
    end

endmodule

// File: tb/tb_ddr3_pll_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ddr3_pll_ctrl
// Directed bench for ddr3_pll_ctrl. Cycle positions are counted in clock edges
// after resetn release (edge 1 = first rising edge with resetn high).
// LOCK_TIMEOUT is shortened so the retry path stays within a short run.
// ----------------------------------------------------------------------------
module tb_ddr3_pll_ctrl;

    localparam int unsigned TB_TIMEOUT = 1000;

    logic       clk      = 1'b0;
    logic       resetn   = 1'b0;
    logic       soft_rst = 1'b0;
    logic       pll_lock = 1'b0;
    logic       pll_reset;
    logic [5:0] pll_icpsel;
    logic [2:0] pll_lpfres;
    logic [1:0] pll_lpfcap;
    logic       pll_enclk0;
    logic       pll_enclk2;
    logic       ddr_rst_n;
    logic       ready;
    logic       fail;
    logic [2:0] retry_cnt;

    int n_checks = 0;
    int n_errors = 0;

`ifdef PLL_CTRL_SWEEP_EN
    int icp_tab[4] = '{20, 28, 12, 20};
    int res_tab[4] = '{2, 2, 3, 4};
`else
    int icp_tab[4] = '{20, 20, 20, 20};
    int res_tab[4] = '{2, 2, 2, 2};
`endif

    ddr3_pll_ctrl #(
        .LOCK_TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .soft_rst   (soft_rst),
        .pll_lock   (pll_lock),
        .pll_reset  (pll_reset),
        .pll_icpsel (pll_icpsel),
        .pll_lpfres (pll_lpfres),
        .pll_lpfcap (pll_lpfcap),
        .pll_enclk0 (pll_enclk0),
        .pll_enclk2 (pll_enclk2),
        .ddr_rst_n  (ddr_rst_n),
        .ready      (ready),
        .fail       (fail),
        .retry_cnt  (retry_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then step off the edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        resetn   = 1'b0;
        soft_rst = 1'b0;
        pll_lock = 1'b0;
        tick(2);
        resetn = 1'b1;
    endtask

    task automatic check_reset_vals(input string pfx);
        check_eq({pfx, "_pll_reset"}, 32'(pll_reset),  32'd1);
        check_eq({pfx, "_enclk0"},    32'(pll_enclk0), 32'd0);
        check_eq({pfx, "_enclk2"},    32'(pll_enclk2), 32'd0);
        check_eq({pfx, "_ddr_rst_n"}, 32'(ddr_rst_n),  32'd0);
        check_eq({pfx, "_ready"},     32'(ready),      32'd0);
        check_eq({pfx, "_fail"},      32'(fail),       32'd0);
        check_eq({pfx, "_retry"},     32'(retry_cnt),  32'd0);
        check_eq({pfx, "_icp"},       32'(pll_icpsel), 32'd20);
        check_eq({pfx, "_lpfres"},    32'(pll_lpfres), 32'd2);
        check_eq({pfx, "_lpfcap"},    32'(pll_lpfcap), 32'd0);
    endtask

    initial begin
        // Reset values, both while held and just after release.
        do_reset();
        check_reset_vals("rst");

        // Nominal bring-up: pll_reset falls at edge 32, lock at edge 42,
        // enclk at edge 300, ddr_rst_n/ready at edge 364.
        tick(31);
        check_eq("hold_pll_reset", 32'(pll_reset), 32'd1);
        tick(1);
        check_eq("wait_pll_reset", 32'(pll_reset), 32'd0);
        tick(10);
        pll_lock = 1'b1;
        tick(257);
        check_eq("pre_enable_enclk0", 32'(pll_enclk0), 32'd0);
        tick(1);
        check_eq("enable_enclk0", 32'(pll_enclk0), 32'd1);
        check_eq("enable_enclk2", 32'(pll_enclk2), 32'd1);
        check_eq("enable_ddr_rst_n", 32'(ddr_rst_n), 32'd0);
        check_eq("enable_ready", 32'(ready), 32'd0);
        tick(63);
        check_eq("pre_run_ddr_rst_n", 32'(ddr_rst_n), 32'd0);
        tick(1);
        check_eq("run_ddr_rst_n", 32'(ddr_rst_n), 32'd1);
        check_eq("run_ready", 32'(ready), 32'd1);
        check_eq("run_retry", 32'(retry_cnt), 32'd0);

        // Lock drops for 2 cycles in RUN: detected 3 edges later, outputs
        // drop on the 4th edge, then a full resequence (RUN again 352 later).
        pll_lock = 1'b0;
        tick(2);
        pll_lock = 1'b1;
        tick(1);
        check_eq("loss_ready_still", 32'(ready), 32'd1);
        tick(1);
        check_eq("loss_ready", 32'(ready), 32'd0);
        check_eq("loss_ddr_rst_n", 32'(ddr_rst_n), 32'd0);
        check_eq("loss_enclk0", 32'(pll_enclk0), 32'd0);
        check_eq("loss_enclk2", 32'(pll_enclk2), 32'd0);
        check_eq("loss_pll_reset", 32'(pll_reset), 32'd1);
        check_eq("loss_retry", 32'(retry_cnt), 32'd0);
        tick(351);
        check_eq("reseq_pre_ready", 32'(ready), 32'd0);
        tick(1);
        check_eq("reseq_ready", 32'(ready), 32'd1);
        check_eq("reseq_retry", 32'(retry_cnt), 32'd0);

        // Async reset in the middle of ENABLE.
        do_reset();
        tick(42);
        pll_lock = 1'b1;
        tick(258);
        check_eq("mid_enable_enclk0", 32'(pll_enclk0), 32'd1);
        tick(10);
        resetn = 1'b0;
        #1;
        check_reset_vals("async");

        // One-cycle lock glitch at stability count 200: ENABLE moves from
        // edge 300 to edge 503, no retry recorded.
        do_reset();
        tick(42);
        pll_lock = 1'b1;
        tick(202);
        pll_lock = 1'b0;
        tick(1);
        pll_lock = 1'b1;
        tick(257);
        check_eq("glitch_pre_enclk0", 32'(pll_enclk0), 32'd0);
        check_eq("glitch_retry", 32'(retry_cnt), 32'd0);
        tick(1);
        check_eq("glitch_enclk0", 32'(pll_enclk0), 32'd1);

        // Lock never asserts: timeouts every 1032 edges, FAIL on the 4th.
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            tick(1031);
            check_eq($sformatf("retry%0d_pre_cnt", k), 32'(retry_cnt), 32'(k - 1));
            check_eq($sformatf("retry%0d_pre_pll_reset", k), 32'(pll_reset), 32'd0);
            check_eq($sformatf("retry%0d_pre_icp", k), 32'(pll_icpsel), 32'(icp_tab[k - 1]));
            tick(1);
            check_eq($sformatf("retry%0d_cnt", k), 32'(retry_cnt), 32'(k));
            check_eq($sformatf("retry%0d_pll_reset", k), 32'(pll_reset), 32'd1);
            if (k < 4) begin
                check_eq($sformatf("retry%0d_fail", k), 32'(fail), 32'd0);
                check_eq($sformatf("retry%0d_icp", k), 32'(pll_icpsel), 32'(icp_tab[k]));
                check_eq($sformatf("retry%0d_lpfres", k), 32'(pll_lpfres), 32'(res_tab[k]));
            end
        end
        check_eq("fail_flag", 32'(fail), 32'd1);
        check_eq("fail_ready", 32'(ready), 32'd0);
        check_eq("fail_icp", 32'(pll_icpsel), 32'(icp_tab[3]));

        // FAIL is sticky even if lock shows up.
        pll_lock = 1'b1;
        tick(400);
        check_eq("fail_sticky", 32'(fail), 32'd1);
        check_eq("fail_enclk0", 32'(pll_enclk0), 32'd0);
        check_eq("fail_pll_reset", 32'(pll_reset), 32'd1);

        // soft_rst out of FAIL restarts from RESET_HOLD with defaults.
        soft_rst = 1'b1;
        tick(1);
        soft_rst = 1'b0;
        check_eq("srst_fail", 32'(fail), 32'd0);
        check_eq("srst_retry", 32'(retry_cnt), 32'd0);
        check_eq("srst_pll_reset", 32'(pll_reset), 32'd1);
        check_eq("srst_icp", 32'(pll_icpsel), 32'd20);
        check_eq("srst_lpfres", 32'(pll_lpfres), 32'd2);
        tick(31);
        check_eq("srst_hold", 32'(pll_reset), 32'd1);
        tick(1);
        check_eq("srst_release", 32'(pll_reset), 32'd0);

        // soft_rst on the same edge as the first timeout wins.
        do_reset();
        tick(1031);
        check_eq("coinc_pre_retry", 32'(retry_cnt), 32'd0);
        soft_rst = 1'b1;
        tick(1);
        soft_rst = 1'b0;
        check_eq("coinc_retry", 32'(retry_cnt), 32'd0);
        check_eq("coinc_fail", 32'(fail), 32'd0);
        check_eq("coinc_pll_reset", 32'(pll_reset), 32'd1);
        check_eq("coinc_icp", 32'(pll_icpsel), 32'd20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
